// File: rtl/serial_subtractor.sv
//-----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial 8-bit subtractor. It computes (A - B - Bin) mod 256 one bit per
// clock, LSB first. A single borrow flip-flop carries the borrow between
// bits. It also produces 8086-style flags: CF (borrow out of bit 7), AF
// (borrow out of bit 3), ZF, SF and OF.
//
// Ports
//   Clk    in   1  rising-edge clock
//   Rst_n  in   1  asynchronous active-low reset
//   Start  in   1  request pulse, sampled only while Busy=0
//   A      in   8  minuend, latched on accept
//   B      in   8  subtrahend, latched on accept
//   Bin    in   1  borrow-in (1 for SBB), latched on accept
//   Busy   out  1  high while an operation is in progress
//   Done   out  1  one-cycle pulse when Diff/flags become valid
//   Diff   out  8  result
//   Bout   out  1  borrow out of bit 7 (CF)
//   AF     out  1  borrow out of bit 3
//   ZF     out  1  Diff == 0
//   SF     out  1  Diff[7]
//   OF     out  1  signed overflow of the subtraction
//
// Timing: the accept edge is E0, and bits 0..7 are processed at E1..E8.
// Results and Done are visible in the cycle after E8. Every output is
// driven straight from a flop.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module serial_subtractor (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bin,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Diff,
    output logic       Bout,
    output logic       AF,
    output logic       ZF,
    output logic       SF,
    output logic       OF
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] a_sh_q, a_sh_d;
    logic [7:0] b_sh_q, b_sh_d;
    logic [7:0] res_q, res_d;
    logic       brw_q, brw_d;
    logic       af_hold_q, af_hold_d;
    // The operand MSBs are shifted out during RUN, so keep copies for OF.
    logic       a_msb_q, a_msb_d;
    logic       b_msb_q, b_msb_d;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] diff_q, diff_d;
    logic       bout_q, bout_d;
    logic       af_q, af_d;
    logic       zf_q, zf_d;
    logic       sf_q, sf_d;
    logic       of_q, of_d;

    // Single-bit full subtractor on the current LSBs of the operand shifters.
    logic       a_bit;
    logic       b_bit;
    logic       d_bit;
    logic       brw_next;
    logic [7:0] res_shifted;

    assign a_bit       = a_sh_q[0];
    assign b_bit       = b_sh_q[0];
    assign d_bit       = a_bit ^ b_bit ^ brw_q;
    assign brw_next    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_q);
    // Result bits enter from the MSB side. After eight shifts, bit 0 has
    // reached Diff[0].
    assign res_shifted = {d_bit, res_q[7:1]};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        brw_d     = brw_q;
        af_hold_d = af_hold_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        diff_d    = diff_q;
        bout_d    = bout_q;
        af_d      = af_q;
        zf_d      = zf_q;
        sf_d      = sf_q;
        of_d      = of_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    a_sh_d  = A;
                    b_sh_d  = B;
                    brw_d   = Bin;
                    idx_d   = 3'd0;
                    res_d   = 8'h00;
                    a_msb_d = A[7];
                    b_msb_d = B[7];
                end
            end

            ST_RUN: begin
                a_sh_d = {1'b0, a_sh_q[7:1]};
                b_sh_d = {1'b0, b_sh_q[7:1]};
                res_d  = res_shifted;
                brw_d  = brw_next;
                idx_d  = idx_q + 3'd1;

                // Borrow out of the low nibble.
                if (idx_q == 3'd3) begin
                    af_hold_d = brw_next;
                end

                // Last bit: publish the result and all flags together.
                if (idx_q == 3'd7) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = res_shifted;
                    bout_d  = brw_next;
                    af_d    = af_hold_q;
                    zf_d    = (res_shifted == 8'h00);
                    sf_d    = res_shifted[7];
                    of_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_shifted[7]);
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            a_sh_q    <= 8'h00;
            b_sh_q    <= 8'h00;
            res_q     <= 8'h00;
            brw_q     <= 1'b0;
            af_hold_q <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            diff_q    <= 8'h00;
            bout_q    <= 1'b0;
            af_q      <= 1'b0;
            zf_q      <= 1'b0;
            sf_q      <= 1'b0;
            of_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            res_q     <= res_d;
            brw_q     <= brw_d;
            af_hold_q <= af_hold_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
            af_q      <= af_d;
            zf_q      <= zf_d;
            sf_q      <= sf_d;
            of_q      <= of_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Diff = diff_q;
    assign Bout = bout_q;
    assign AF   = af_q;
    assign ZF   = zf_q;
    assign SF   = sf_q;
    assign OF   = of_q;

endmodule

// File: tb/tb_serial_subtractor.sv
//-----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor. Every expected value below is
// hand-computed from A - B - Bin. Outputs are sampled 1 ns after the rising
// edge.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_subtractor;

    logic       Clk;
    logic       Rst_n;
    logic       Start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       Busy;
    logic       Done;
    logic [7:0] Diff;
    logic       Bout;
    logic       AF;
    logic       ZF;
    logic       SF;
    logic       OF;

    int vectors;
    int miscompares;

    serial_subtractor dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Busy  (Busy),
        .Done  (Done),
        .Diff  (Diff),
        .Bout  (Bout),
        .AF    (AF),
        .ZF    (ZF),
        .SF    (SF),
        .OF    (OF)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present the operands before an edge, then return 1 ns after the accept
    // edge with Start dropped.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge Clk);
        A     = a;
        B     = b;
        Bin   = bin;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    // Count the edges until Done is seen, bounded. Also count the samples
    // with Busy high, including the one taken on entry.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = (Busy === 1'b1) ? 1 : 0;
        while (Done !== 1'b1 && edges < 30) begin
            @(posedge Clk);
            #1;
            edges++;
            if (Busy === 1'b1) busy_cycles++;
        end
    endtask

    task automatic check_res(input string tag, input logic [7:0] ediff, input logic ebout,
                             input logic eaf, input logic ezf, input logic esf, input logic eof);
        chk({tag, ".diff"}, {24'h0, Diff}, {24'h0, ediff});
        chk({tag, ".cf"},   {31'h0, Bout}, {31'h0, ebout});
        chk({tag, ".af"},   {31'h0, AF},   {31'h0, eaf});
        chk({tag, ".zf"},   {31'h0, ZF},   {31'h0, ezf});
        chk({tag, ".sf"},   {31'h0, SF},   {31'h0, esf});
        chk({tag, ".of"},   {31'h0, OF},   {31'h0, eof});
    endtask

    initial begin
        int n;
        int nb;
        int done_seen;

        vectors     = 0;
        miscompares = 0;
        Rst_n = 1'b0;
        Start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        Bin   = 1'b0;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst.busy", {31'h0, Busy}, 32'h0);
        chk("rst.done", {31'h0, Done}, 32'h0);
        check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Simple subtract: check latency and Busy width too.
        start_op(8'h50, 8'h20, 1'b0);
        chk("simple.busy_after_e0", {31'h0, Busy}, 32'h1);
        wait_done(n, nb);
        chk("simple.latency", n, 8);
        chk("simple.busy_cycles", nb, 8);
        chk("simple.busy_in_done", {31'h0, Busy}, 32'h0);
        check_res("simple", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        chk("simple.done_one_cycle", {31'h0, Done}, 32'h0);

        // Wrap-around
        start_op(8'h00, 8'h01, 1'b0);
        wait_done(n, nb);
        chk("wrap.latency", n, 8);
        check_res("wrap", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Signed overflow
        start_op(8'h80, 8'h01, 1'b0);
        wait_done(n, nb);
        chk("ovf.latency", n, 8);
        check_res("ovf", 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // SBB to zero
        start_op(8'h05, 8'h04, 1'b1);
        wait_done(n, nb);
        chk("sbb.latency", n, 8);
        check_res("sbb", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Start re-pulsed mid-RUN must be ignored. The outputs hold the
        // previous result (the SBB one) while the operation runs.
        start_op(8'h50, 8'h20, 1'b0);
        repeat (3) @(posedge Clk);
        #1;
        chk("midrun.diff_held", {24'h0, Diff}, 32'h00);
        chk("midrun.zf_held", {31'h0, ZF}, 32'h1);
        A     = 8'hFF;
        B     = 8'hFF;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_done(n, nb);
        chk("midrun.latency", n + 4, 8);
        check_res("midrun", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge Clk);
        #1;
        chk("midrun.no_requeue_busy", {31'h0, Busy}, 32'h0);

        // Start asserted during the Done cycle is accepted at the next edge.
        start_op(8'h50, 8'h20, 1'b0);
        wait_done(n, nb);
        chk("b2b.first_latency", n, 8);
        A     = 8'h00;
        B     = 8'h01;
        Bin   = 1'b0;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        chk("b2b.accepted_busy", {31'h0, Busy}, 32'h1);
        chk("b2b.done_dropped", {31'h0, Done}, 32'h0);
        check_res("b2b.first_held", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done(n, nb);
        chk("b2b.done_gap", n + 1, 9);
        check_res("b2b.second", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset after 4 RUN edges: outputs clear immediately, and no Done
        // follows.
        start_op(8'h80, 8'h01, 1'b0);
        repeat (4) @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst_mid.busy", {31'h0, Busy}, 32'h0);
        chk("rst_mid.done", {31'h0, Done}, 32'h0);
        check_res("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            if (Done === 1'b1) done_seen++;
        end
        chk("rst_mid.no_done", done_seen, 0);
        chk("rst_mid.idle", {31'h0, Busy}, 32'h0);

        start_op(8'h12, 8'h34, 1'b0);
        wait_done(n, nb);
        chk("post_rst.latency", n, 8);
        check_res("post_rst", 8'hDE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
